// File: rtl/mips_cpu_mem_master.sv
// rtl/mips_cpu_mem_master.sv - CPU load/store master for a word-addressed Avalon-style RAM
//
// Accepts one byte/halfword/word load or store at a time. It builds the aligned
// bus address, lane enables and replicated write data, and holds them while the
// RAM stalls. For loads it extracts and extends the addressed lanes. Each request
// ends with a single-cycle done pulse.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req, we, size,       request strobe (sampled only when idle), store flag,
//   unsigned_ld          size (00 byte, 01 half, 10 word), zero-extend flag
//   addr, wdata          byte address, right-justified store data
//   busy, done           high outside IDLE, one-cycle completion pulse
//   rdata, misaligned    extended load result, rejected-request qualifier of done
//   address, read, write bus address and transaction strobes
//   waitrequest          RAM stall
//   writedata,           lane-replicated store data,
//   byteenable           active byte lanes
//   readdata             registered RAM read data
module mips_cpu_mem_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUS  = 3'd1,
    S_CAP  = 3'd2,
    S_ERR  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Request fields latched in IDLE so the CPU side may change during the access.
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;

  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [15:0] lane_data;
  logic [31:0] ld_ext;

  // Decode the incoming request into lane enables, replicated data and the
  // alignment verdict.
  always_comb begin
    req_err = 1'b0;
    req_be  = 4'b0000;
    req_wd  = wdata;
    case (size)
      2'b00: begin
        req_be = 4'b0001 << addr[1:0];
        req_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_err = addr[0];
        req_be  = addr[1] ? 4'b1100 : 4'b0011;
        req_wd  = {2{wdata[15:0]}};
      end
      2'b10: begin
        req_err = |addr[1:0];
        req_be  = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    lane_data = 16'(readdata >> {lane_q, 3'b000});
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, lane_data[7:0]}
                              : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, lane_data}
                              : {{16{lane_data[15]}}, lane_data};
      default: ld_ext = readdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch and load result register
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      address    <= 32'h0;
      byteenable <= 4'b0000;
      writedata  <= 32'h0;
      rdata      <= 32'h0;
    end else begin
      if (state == S_IDLE && req) begin
        we_q       <= we;
        uns_q      <= unsigned_ld;
        err_q      <= req_err;
        size_q     <= size;
        lane_q     <= addr[1:0];
        address    <= {addr[31:2], 2'b00};
        byteenable <= req_be;
        writedata  <= req_wd;
      end
      // readdata belongs to the access that just left BUS.
      if (state == S_CAP) begin
        rdata <= ld_ext;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = req_err ? S_ERR : S_BUS;
      S_BUS:   if (!waitrequest) state_nxt = we_q ? S_FIN : S_CAP;
      S_CAP:   state_nxt = S_FIN;
      S_ERR:   state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode only from registered state, so waitrequest and readdata
  // never reach an output combinationally.
  always_comb begin
    busy       = (state != S_IDLE);
    read       = (state == S_BUS) && !we_q;
    write      = (state == S_BUS) && we_q;
    done       = (state == S_FIN);
    misaligned = (state == S_FIN) && err_q;
  end

endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// tb/tb_mips_cpu_mem_master.sv - directed and randomised checks of mips_cpu_mem_master against a byte-level memory model
module tb_mips_cpu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  mips_cpu_mem_master dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .misaligned(misaligned), .address(address),
    .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Bus-side RAM: 1024 words, registered read data, byte-enabled writes.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      readdata <= 32'h0;
    end else begin
      if (read && !waitrequest) readdata <= ram[address[11:2]];
      if (write && !waitrequest)
        for (int j = 0; j < 4; j++)
          if (byteenable[j]) ram[address[11:2]][8*j +: 8] <= writedata[8*j +: 8];
    end
  end

  // Reference memory: plain byte array indexed by addr[11:0].
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] last_rdata;

  int passes = 0;
  int total  = 0;

  logic [31:0] obs_rdata;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd;
  int          obs_done_cyc;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic u);
    int    i0;
    longint v;
    i0 = int'(a[11:0]);
    v  = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[i0 + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int nwait);
    int          n, bus_cnt, first_bus, done_cyc, exp_cyc;
    bit          mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd;
    logic [69:0] cap;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz == 2'd3) || ((a % n) != 0);
    exp_be = 4'(((1 << n) - 1) << (a % 4));
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
    exp_rd  = (!mis && !w) ? ref_load(a, n, u) : last_rdata;
    exp_cyc = mis ? 2 : (w ? 2 + nwait : 3 + nwait);
    bus_cnt = 0; first_bus = 0; done_cyc = 0; cap = '0;

    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
    waitrequest = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req = 1'b0;
      chk("rw_exclusive", 72'(read & write), 72'd0);
      if (read || write) begin
        bus_cnt++;
        if (bus_cnt == 1) begin
          first_bus = c;
          cap = {address, byteenable, writedata, read, write};
          obs_be = byteenable;
          obs_wd = writedata;
          chk("bus_address", 72'(address), 72'({a[31:2], 2'b00}));
          chk("bus_byteenable", 72'(byteenable), 72'(exp_be));
          chk("bus_writedata", 72'(w ? writedata : exp_wd), 72'(exp_wd));
          chk("bus_strobe", 72'({read, write}), 72'({~w, w}));
        end else begin
          chk("bus_hold", 72'({address, byteenable, writedata, read, write}), 72'(cap));
        end
        waitrequest = (bus_cnt <= nwait);
      end
      if (done) begin
        done_cyc  = c;
        obs_rdata = rdata;
        chk("misaligned", 72'(misaligned), 72'(mis));
        break;
      end
    end
    waitrequest = 1'b0;
    obs_done_cyc = done_cyc;
    chk("done_cycle", 72'(done_cyc), 72'(exp_cyc));
    chk("rdata", 72'(obs_rdata), 72'(exp_rd));
    chk("bus_cycles", 72'(bus_cnt), 72'(mis ? 0 : nwait + 1));
    if (!mis) chk("first_bus_cycle", 72'(first_bus), 72'd1);
    @(negedge clk);
    chk("done_one_cycle", 72'({done, busy}), 72'd0);
    if (w && !mis)
      for (int i = 0; i < n; i++) ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
    last_rdata = exp_rd;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    last_rdata = 32'h0;
    obs_rdata = 32'h0; obs_be = 4'h0; obs_wd = 32'h0; obs_done_cyc = 0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 72'({read, write, done, misaligned, busy}), 72'd0);
    chk("reset_rdata", 72'(rdata), 72'd0);
    chk("reset_address", 72'(address), 72'd0);
    chk("reset_writedata", 72'(writedata), 72'd0);
    chk("reset_byteenable", 72'(byteenable), 72'd0);
    reset = 1'b0;

    access(1'b1, 2'b10, 1'b0, 32'hBFC00004, 32'h8899AABB, 0);
    access(1'b0, 2'b10, 1'b0, 32'hBFC00004, 32'h0, 0);
    chk("lw_value", 72'(obs_rdata), 72'h8899AABB);
    chk("lw_be", 72'(obs_be), 72'hF);
    chk("lw_done", 72'(obs_done_cyc), 72'd3);
    access(1'b0, 2'b00, 1'b0, 32'hBFC00007, 32'h0, 0);
    chk("lb_value", 72'(obs_rdata), 72'hFFFFFF88);
    chk("lb_be", 72'(obs_be), 72'h8);
    access(1'b0, 2'b00, 1'b1, 32'hBFC00007, 32'h0, 0);
    chk("lbu_value", 72'(obs_rdata), 72'h00000088);
    access(1'b0, 2'b01, 1'b1, 32'hBFC00006, 32'h0, 0);
    chk("lhu_value", 72'(obs_rdata), 72'h00008899);

    access(1'b1, 2'b00, 1'b0, 32'hBFC00001, 32'h123456CD, 0);
    chk("sb_wd", 72'(obs_wd), 72'hCDCDCDCD);
    chk("sb_be", 72'(obs_be), 72'h2);
    chk("sb_rdata_kept", 72'(obs_rdata), 72'h00008899);
    access(1'b0, 2'b10, 1'b0, 32'hBFC00000, 32'h0, 0);
    chk("sb_readback", 72'(obs_rdata), 72'h0000CD00);

    access(1'b1, 2'b01, 1'b0, 32'hBFC00002, 32'h0000BEEF, 5);
    chk("sh_be", 72'(obs_be), 72'hC);
    chk("sh_done", 72'(obs_done_cyc), 72'd7);

    access(1'b0, 2'b10, 1'b0, 32'hBFC00002, 32'h0, 0);
    chk("lw_mis_done", 72'(obs_done_cyc), 72'd2);
    access(1'b0, 2'b01, 1'b0, 32'hBFC00001, 32'h0, 0);
    chk("lh_mis_done", 72'(obs_done_cyc), 72'd2);

    // Reset while a load is stalled on the bus.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'hBFC00010; waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; waitrequest = 1'b1;
    chk("mid_read_up", 72'(read), 72'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_out", 72'({read, write, busy, done}), 72'd0);
    reset = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    last_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_reset_no_done", 72'({done, busy}), 72'd0);
    end
    access(1'b1, 2'b10, 1'b0, 32'hBFC00010, 32'hCAFEF00D, 1);
    access(1'b0, 2'b01, 1'b0, 32'hBFC00012, 32'h0, 2);
    chk("post_reset_lh", 72'(obs_rdata), 72'hFFFFCAFE);

    for (int k = 0; k < 1000; k++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a = 32'hBFC00000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             32'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
